// File: rtl/xor4_parity_rx.sv
// rtl/xor4_parity_rx.sv - serial receiver for a 4-bit nibble with even-parity and stop-bit checks
module xor4_parity_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             rx_m;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       bit_idx;
  logic [3:0]       shreg;
  logic             par_bit;

  logic             bit_end;
  logic             half_end;
  logic             cnt_clr;
  logic             take_data;
  logic             take_par;
  logic             finish;

  assign bit_end  = (cnt == BIT_LAST);
  assign half_end = (cnt == HALF_LAST);
  assign busy     = (state != S_IDLE);

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode and per-state strobes for the datapath.
  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    take_data = 1'b0;
    take_par  = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (half_end) begin
          cnt_clr = 1'b1;
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_clr   = 1'b1;
          take_data = 1'b1;
          if (bit_idx == 2'd3) state_n = S_PARITY;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_clr  = 1'b1;
          take_par = 1'b1;
          state_n  = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_clr = 1'b1;
          finish  = 1'b1;
          state_n = rx_s ? S_IDLE : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_s) state_n = S_IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  // Bit-period counter, cleared on every state entry and between data bits.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  // Data bit index and shift register; index only advances while in DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= 2'd0;
      shreg   <= 4'd0;
      par_bit <= 1'b0;
    end else begin
      if (state != S_DATA) bit_idx <= 2'd0;
      else if (take_data)  bit_idx <= bit_idx + 2'd1;
      if (take_data) shreg[bit_idx] <= rx_s;
      if (take_par)  par_bit <= rx_s;
    end
  end

  // Result registers load together with the one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= 4'd0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= finish;
      if (finish) begin
        data       <= shreg;
        parity_err <= par_bit ^ (^shreg);
        frame_err  <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_xor4_parity_rx.sv
// tb/tb_xor4_parity_rx.sv - randomized self-checking bench for xor4_parity_rx
module tb_xor4_parity_rx;
  localparam int CPB  = 8;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [3:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int nvalid = 0;
  logic [5:0] exp_q[$];
  logic [3:0] last_data = 4'd0;

  xor4_parity_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every valid must match the oldest expected frame result.
  always @(negedge clk) begin
    if (!rst && valid) begin
      nvalid++;
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("data", {28'd0, data}, {28'd0, e[3:0]});
        check("parity_err", {31'd0, parity_err}, {31'd0, e[4]});
        check("frame_err", {31'd0, frame_err}, {31'd0, e[5]});
      end
    end
  end

  task automatic drive_bit(input logic b, input logic glitch);
    @(negedge clk);
    rx = glitch ? ~b : b;
    repeat (CPB - 1) begin
      @(negedge clk);
      rx = b;
    end
  endtask

  // Sends one frame; expectation is queued before the stop bit is driven.
  task automatic send_frame(input logic [3:0] n, input logic bad_par,
                            input logic bad_stop, input logic glitchy);
    logic par;
    par = ($countones(n) % 2 == 1) ^ bad_par;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(n[i], glitchy && ($urandom_range(0, 1) == 1));
    drive_bit(par, glitchy && ($urandom_range(0, 1) == 1));
    exp_q.push_back({bad_stop, bad_par, n});
    last_data = n;
    drive_bit(~bad_stop, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int v0;
    logic seen;

    // Reset then idle.
    repeat (3) @(negedge clk);
    check("rst_data", {28'd0, data}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_perr", {31'd0, parity_err}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (busy || valid) seen = 1'b1;
    end
    check("idle_quiet", {31'd0, seen}, 0);
    check("idle_nvalid", nvalid, 0);
    check("idle_data", {28'd0, data}, 0);

    // All 16 nibbles with correct parity, back to back.
    for (int n = 0; n < 16; n++) send_frame(4'(n), 1'b0, 1'b0, 1'b0);
    drain();
    check("sweep_nvalid", nvalid, 16);

    // Bad parity on 0011 (x0..x3) -> data 1100.
    send_frame(4'b1100, 1'b1, 1'b0, 1'b0);
    drain();
    check("badpar_data", {28'd0, data}, 32'hC);

    // Bad stop on 0101 (x0..x3) with break held low.
    v0 = nvalid;
    send_frame(4'b1010, 1'b0, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("break_valid_once", nvalid, v0 + 1);
    check("break_busy", {31'd0, busy}, 1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("break_busy_release", {31'd0, busy}, 0);
    repeat (100) @(negedge clk);
    check("break_no_second", nvalid, v0 + 1);

    // Glitch: two low cycles give a false start.
    v0 = nvalid;
    seen = 1'b0;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("glitch_busy_pulse", {31'd0, seen}, 1);
    repeat (100) @(negedge clk);
    check("glitch_no_valid", nvalid, v0);
    check("glitch_data", {28'd0, data}, {28'd0, last_data});
    check("glitch_idle", {31'd0, busy}, 0);

    // Randomized frames with optional errors, gaps and intra-bit glitches.
    for (int i = 0; i < 40; i++) begin
      logic bp, bs;
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      send_frame(4'($urandom_range(0, 15)), bp, bs, 1'b1);
      if (bs) begin
        repeat ($urandom_range(0, 10)) @(negedge clk);
        rx = 1'b1;
        repeat ($urandom_range(2, 4)) @(negedge clk);
      end else begin
        rx = 1'b1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();

    // Back-to-back 0001 then 1110, then reset during a third frame.
    v0 = nvalid;
    send_frame(4'b1000, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0111, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drain();
    check("b2b_nvalid", nvalid, v0 + 2);
    check("b2b_data", {28'd0, data}, 32'h7);
    drive_bit(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_data", {28'd0, data}, 0);
    check("midrst_valid", {31'd0, valid}, 0);
    check("midrst_perr", {31'd0, parity_err}, 0);
    check("midrst_ferr", {31'd0, frame_err}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    rx = 1'b1;
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("midrst_no_third", nvalid, v0 + 2);
    check("midrst_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor4_parity_rx.md
Name: xor4_parity_rx

Overview:
- Serial receiver for a 4-bit data frame protected by an even-parity bit.
- The parity bit is the XOR of the four data bits, x0^x1^x2^x3, the same function as the xor4 gate.
- Sits between an FPGA input pin and the user logic on the 12 MHz board clock.
- Reassembles nibble x0..x3, checks parity and stop bit, and presents the result with a one-cycle valid strobe.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per serial bit. 12 MHz / 115200 rounds to 104. Must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2: cycles from the detected start edge to the start-bit sample point.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  asynchronous serial line. Idle level is high.
- data  output  4  received nibble. data[0]=x0 (first data bit) through data[3]=x3.
- valid  output  1  one-cycle pulse: a frame has completed and data and the flags are updated.
- parity_err  output  1  received parity bit != x0^x1^x2^x3 for the last frame.
- frame_err  output  1  stop bit sampled low for the last frame.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Frame format on rx: start(0), x0, x1, x2, x3, parity, stop(1). Seven bits, LSB first.
- Reset (rst=1 at a clk edge):
  - Outputs: data=0, valid=0, parity_err=0, frame_err=0, busy=0.
  - Internal: state=IDLE, synchroniser flops=1, bit counter=0, cycle counter=0.
  - Reset mid-frame abandons the frame with no valid pulse.
- Input synchroniser: two flops, giving rx_s. All decisions use rx_s only.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
- States:
  - IDLE: busy=0. rx_s==0 -> START with counter cleared.
  - START: at count==HALF_BIT-1, sample rx_s.
    - rx_s==1: false start (glitch) -> IDLE, no outputs change.
    - rx_s==0: -> DATA with counter and bit index cleared.
  - DATA: at count==CLKS_PER_BIT-1, sample rx_s into shift register position bit_idx.
    - Then increment bit_idx.
    - After bit_idx 3 -> PARITY.
  - PARITY: at count==CLKS_PER_BIT-1, capture the parity bit -> STOP.
  - STOP: at count==CLKS_PER_BIT-1, sample the stop bit.
    - Next edge: valid=1 for exactly one cycle, and data, parity_err and frame_err are loaded together.
    - Stop bit 1 -> IDLE.
    - Stop bit 0 -> WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then -> IDLE. This prevents a held-low line (break) from retriggering.
- Sampling points: start bit at mid-bit. Each later bit is sampled one full CLKS_PER_BIT after the previous sample, i.e. at mid-bit.
- Latency: valid asserts 2 + HALF_BIT + 6*CLKS_PER_BIT + 1 cycles (±1) after the falling edge of the start bit at the rx pin.
- data, parity_err and frame_err:
  - Hold their values until the next valid.
  - Update only on valid, including frames that contain errors.
  - A false start changes nothing.
- Back-to-back frames: a start bit immediately following a good stop bit is accepted. IDLE is entered in the valid cycle and sees rx_s low on the next cycle.
- Parity and frame errors are independent; both may be set for the same frame.
- rx toggling inside a bit period is ignored except at the sample point.

Test Plan (CLKS_PER_BIT=8, HALF_BIT=4):
- Reset then idle: rst high for 3 cycles, rx=1 for 200 cycles -> data=0, valid never asserts, busy=0 throughout.
- Sweep all 16 nibbles with correct parity, x0..x3 from 0000 to 1111 as in the xor4 sweep:
  - Every valid has data matching and parity_err=0, frame_err=0.
  - Example: x0..x3=1,0,1,1 gives parity 1 and data=4'b1101.
- Bad parity: send 0011 with parity bit 1 -> valid pulse, data=4'b1100, parity_err=1, frame_err=0.
- Bad stop: send 0101 with stop=0 and hold rx low 40 cycles, then high.
  - valid pulse with frame_err=1.
  - busy stays high until rx returns high.
  - No second valid.
- Glitch: rx low for 2 cycles then high -> busy pulses, valid never asserts, data unchanged.
- Back-to-back frames 0001 then 1110 with no idle gap, then assert rst mid-way through a third frame:
  - Two valid pulses, data=4'b1000 then 4'b0111.
  - After rst: all outputs 0, no third valid.
